tl_sched_timed: RTL and testbench

Timed scheduler for the two-road intersection lights. It sequences the A/B light pair through green, yellow and all-red phases. Each phase lasts a counted number of `tick` pulses, subject to minimum and maximum green limits driven by the traffic sensors `Ta` and `Tb`. It sits above the light-output decode and replaces the untimed next-state logic. An optional pedestrian walk phase is inserted during all-red.

---
 rtl/tl_pkg.sv | 19 +
 rtl/tl_dwell_timer.sv | 29 ++
 rtl/tl_sched_timed.sv | 132 +++++++++++++
 tb/tb_tl_sched_timed.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared light encodings and phase enumeration for the timed intersection scheduler.
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        AG = 3'd0,
        AY = 3'd1,
        AR = 3'd2,
        BG = 3'd3,
        BY = 3'd4,
        BR = 3'd5,
        WA = 3'd6,
        WB = 3'd7
    } state_e;

endpackage

// File: rtl/tl_dwell_timer.sv
// Saturating phase dwell counter; o_e reports the elapsed count including the current tick.
module tl_dwell_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_tick,
    output logic [CNT_W:0]   o_e
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;
    // One bit wider so cnt+1 never wraps at saturation.
    assign o_e   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tl_sched_timed.sv
// Timed two-road light scheduler with min/max green limits.
// Optional pedestrian walk phase during all-red is enabled by defining TL_PED_EN.
module tl_sched_timed
    import tl_pkg::*;
#(
    parameter int unsigned G_MIN   = 5,
    parameter int unsigned G_MAX   = 20,
    parameter int unsigned Y_TIME  = 3,
    parameter int unsigned AR_TIME = 1,
    parameter int unsigned W_TIME  = 4,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       Ta,
    input  logic       Tb,
`ifdef TL_PED_EN
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
`endif
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] state
);

    localparam logic [CNT_W:0] L_GMIN = (CNT_W+1)'(G_MIN);
    localparam logic [CNT_W:0] L_GMAX = (CNT_W+1)'(G_MAX);
    localparam logic [CNT_W:0] L_Y    = (CNT_W+1)'(Y_TIME);
    localparam logic [CNT_W:0] L_AR   = (CNT_W+1)'(AR_TIME);
`ifdef TL_PED_EN
    localparam logic [CNT_W:0] L_W    = (CNT_W+1)'(W_TIME);
`endif

    state_e         r_state;
    state_e         w_next;
    logic           w_clr;
    logic [CNT_W:0] w_e;
    logic           w_to_walk_a;
    logic           w_to_walk_b;

`ifdef TL_PED_EN
    logic r_pend;
    logic r_ack;

    assign w_to_walk_a = r_pend;
    assign w_to_walk_b = r_pend;
`else
    assign w_to_walk_a = 1'b0;
    assign w_to_walk_b = 1'b0;
`endif

    tl_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_tick  (tick),
        .o_e     (w_e)
    );

    always_comb begin
        w_next = r_state;
        if (tick) begin
            case (r_state)
                AG: if (w_e >= L_GMIN && (!Ta || w_e >= L_GMAX)) w_next = AY;
                AY: if (w_e >= L_Y) w_next = AR;
                AR: if (w_e >= L_AR) w_next = w_to_walk_a ? WA : BG;
                BG: if (w_e >= L_GMIN && (!Tb || w_e >= L_GMAX)) w_next = BY;
                BY: if (w_e >= L_Y) w_next = BR;
                BR: if (w_e >= L_AR) w_next = w_to_walk_b ? WB : AG;
`ifdef TL_PED_EN
                WA: if (w_e >= L_W) w_next = BG;
                WB: if (w_e >= L_W) w_next = AG;
`endif
                default: w_next = AG;
            endcase
        end
    end

    // Every legal transition changes the state, so a change is the counter clear.
    assign w_clr = (w_next != r_state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= AG;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef TL_PED_EN
    // Ack is registered on entry so it is high exactly in the first walk cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_ack <= w_clr && (w_next == WA || w_next == WB);
            if (r_ack) begin
                r_pend <= 1'b0;
            end else if (ped_req) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign ped_ack = r_ack;
    assign walk    = (r_state == WA) || (r_state == WB);
`endif

    always_comb begin
        La = GREEN;
        Lb = RED;
        case (r_state)
            AG: begin La = GREEN;  Lb = RED;    end
            AY: begin La = YELLOW; Lb = RED;    end
            BG: begin La = RED;    Lb = GREEN;  end
            BY: begin La = RED;    Lb = YELLOW; end
            AR, BR: begin La = RED; Lb = RED;   end
`ifdef TL_PED_EN
            WA, WB: begin La = RED; Lb = RED;   end
`endif
            default: begin La = GREEN; Lb = RED; end
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_tl_sched_timed.sv
// Directed bench for tl_sched_timed: timing of phases, G_MAX, sparse ticks, async reset.
module tb_tl_sched_timed;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic       ped_ack;
    logic       walk;
    logic [1:0] La;
    logic [1:0] Lb;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    tl_sched_timed dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .Ta      (Ta),
        .Tb      (Tb),
`ifdef TL_PED_EN
        .ped_req (ped_req),
        .ped_ack (ped_ack),
        .walk    (walk),
`endif
        .La      (La),
        .Lb      (Lb),
        .state   (state)
    );

`ifndef TL_PED_EN
    assign ped_ack = 1'b0;
    assign walk    = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic [1:0] la,
                          input logic [1:0] lb);
        chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
        chk({tag, ".La"}, {6'd0, La}, {6'd0, la});
        chk({tag, ".Lb"}, {6'd0, Lb}, {6'd0, lb});
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b1;
        Ta      = 1'b0;
        Tb      = 1'b1;
        ped_req = 1'b0;
        #1;
        chk_st("reset", 3'd0, 2'b00, 2'b10);

        // Ta=0, Tb=1: AG 5, AY 3, AR 1, then BG
        @(negedge clk) reset_n = 1'b1;
        cyc(4); chk_st("ag_last", 3'd0, 2'b00, 2'b10);
        cyc(1); chk_st("ay_first", 3'd1, 2'b01, 2'b10);
        cyc(2); chk_st("ay_last", 3'd1, 2'b01, 2'b10);
        cyc(1); chk_st("ar", 3'd2, 2'b10, 2'b10);
        cyc(1); chk_st("bg_first", 3'd3, 2'b10, 2'b00);
        Ta = 1'b1;

        // Tb=1 holds BG for G_MAX, then Ta=1 holds AG for G_MAX
        cyc(19); chk_st("bg_max_last", 3'd3, 2'b10, 2'b00);
        cyc(1);  chk_st("by_first", 3'd4, 2'b10, 2'b01);
        cyc(23); chk_st("ag_max_last", 3'd0, 2'b00, 2'b10);
        cyc(1);  chk_st("ay_after_max", 3'd1, 2'b01, 2'b10);
        cyc(4);  chk_st("bg_again", 3'd3, 2'b10, 2'b00);
        Tb = 1'b0;
        cyc(5);  chk_st("bg_min_exit", 3'd4, 2'b10, 2'b01);

        // Asynchronous reset mid-BY
        cyc(1);
        #2 reset_n = 1'b0;
        #1 chk_st("reset_mid_by", 3'd0, 2'b00, 2'b10);

        // Tick every 4th cycle, Ta high only between ticks: AG lasts 20 clocks
        @(negedge clk) reset_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick = (i % 4 == 0);
            Ta   = (i % 4 != 0);
            @(negedge clk);
            if (i == 19) chk_st("sparse_ag_last", 3'd0, 2'b00, 2'b10);
        end
        chk_st("sparse_ay", 3'd1, 2'b01, 2'b10);
        tick = 1'b0;
        cyc(6);
        chk_st("no_tick_hold", 3'd1, 2'b01, 2'b10);

`ifdef TL_PED_EN
        @(negedge clk) reset_n = 1'b0;
        tick = 1'b1; Ta = 1'b0; Tb = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        ped_req = 1'b1;
        cyc(1); ped_req = 1'b0;
        cyc(7); chk_st("ped_ar", 3'd2, 2'b10, 2'b10);
        chk("ped_ar.walk", {7'd0, walk}, 8'd0);
        cyc(1); chk_st("ped_wa", 3'd6, 2'b10, 2'b10);
        chk("ped_ack_hi", {7'd0, ped_ack}, 8'd1);
        chk("ped_walk_1", {7'd0, walk}, 8'd1);
        cyc(1); chk("ped_ack_lo", {7'd0, ped_ack}, 8'd0);
        cyc(2); chk("ped_walk_4", {7'd0, walk}, 8'd1);
        cyc(1); chk_st("ped_bg", 3'd3, 2'b10, 2'b00);
        chk("ped_bg.walk", {7'd0, walk}, 8'd0);
        cyc(9); chk_st("ped_br_skip", 3'd0, 2'b00, 2'b10);
        ped_req = 1'b1;
        cyc(1); ped_req = 1'b0;
        cyc(9); chk_st("ped_wa2", 3'd6, 2'b10, 2'b10);
        #2 reset_n = 1'b0;
        #1 chk_st("ped_reset", 3'd0, 2'b00, 2'b10);
        chk("ped_reset.walk", {7'd0, walk}, 8'd0);
        chk("ped_reset.ack", {7'd0, ped_ack}, 8'd0);
        @(negedge clk) reset_n = 1'b1;
        cyc(9); chk_st("ped_pend_clr", 3'd3, 2'b10, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
